// File: rtl/ov5640_dvp_capture.sv
// OV5640 DVP capture: waits for sensor config, skips settling frames, then packs
// byte pairs into RGB565 pixels with coordinates, frame-start and geometry checks.
module ov5640_dvp_capture #(
  parameter int unsigned IMAGE_WIDTH  = 1280,
  parameter int unsigned IMAGE_HEIGHT = 720,
  parameter int unsigned SKIP_FRAMES  = 10
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        cfg_done,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  output logic [15:0] pix_data,
  output logic        pix_de,
  output logic        pix_vs,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        size_err,
  output logic        capture_on
);

  localparam int unsigned CW  = 12;
  localparam int unsigned SW  = 8;
  localparam int unsigned SKW = SW + 1;
  localparam logic [CW-1:0] WIDTH_C  = CW'(IMAGE_WIDTH);
  localparam logic [CW-1:0] HEIGHT_C = CW'(IMAGE_HEIGHT);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    WAIT_CFG = 2'd0,
    SKIP     = 2'd1,
    ACTIVE   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic          vs_q, vs_prev_q, href_q, href_prev_q;
  logic [7:0]    data_q;
  logic [SW-1:0] skip_cnt_q, skip_cnt_d;
  logic [CW-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic          phase_q, phase_d;
  logic [7:0]    hi_q, hi_d;
  logic          line_err_q, line_err_d;
  logic [15:0]   pix_data_q, pix_data_d;
  logic [CW-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic          pix_de_q, pix_de_d, pix_vs_q, pix_vs_d;
  logic          size_err_q, size_err_d, capture_on_q, capture_on_d;

  logic vs_rise, href_fall, skip_last, frame_start;

  assign vs_rise     = vs_q & ~vs_prev_q;
  assign href_fall   = href_prev_q & ~href_q;
  assign skip_last   = (SKW'(skip_cnt_q) + SKW'(1)) >= SKW'(SKIP_FRAMES);
  assign frame_start = vs_rise && ((state_q == ACTIVE) || ((state_q == SKIP) && skip_last));

  // Single input register stage plus edge-detect history
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      vs_q        <= 1'b0;
      vs_prev_q   <= 1'b0;
      href_q      <= 1'b0;
      href_prev_q <= 1'b0;
      data_q      <= '0;
    end else begin
      vs_q        <= cmos_vsync;
      vs_prev_q   <= vs_q;
      href_q      <= cmos_href;
      href_prev_q <= href_q;
      data_q      <= cmos_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= WAIT_CFG;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!cfg_done) begin
      state_d = WAIT_CFG;
    end else begin
      case (state_q)
        WAIT_CFG: state_d = SKIP;
        SKIP:     if (vs_rise && skip_last) state_d = ACTIVE;
        ACTIVE:   state_d = ACTIVE;
        default:  state_d = WAIT_CFG;
      endcase
    end
  end

  // Frame clear outranks end-of-line and packing; cfg loss outranks everything
  always_comb begin
    skip_cnt_d   = skip_cnt_q;
    x_cnt_d      = x_cnt_q;
    y_cnt_d      = y_cnt_q;
    phase_d      = phase_q;
    hi_d         = hi_q;
    line_err_d   = line_err_q;
    pix_data_d   = pix_data_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_de_d     = 1'b0;
    pix_vs_d     = 1'b0;
    size_err_d   = 1'b0;
    capture_on_d = (state_d == ACTIVE);

    if (!cfg_done) begin
      skip_cnt_d = '0;
      phase_d    = 1'b0;
    end else if (state_q == WAIT_CFG) begin
      skip_cnt_d = '0;
    end else if (frame_start) begin
      if (state_q == SKIP) skip_cnt_d = skip_cnt_q + SW'(1);
      pix_vs_d   = 1'b1;
      size_err_d = (state_q == ACTIVE) && ((y_cnt_q != HEIGHT_C) || line_err_q);
      line_err_d = 1'b0;
      x_cnt_d    = '0;
      y_cnt_d    = '0;
      phase_d    = 1'b0;
    end else if (state_q == SKIP) begin
      if (vs_rise) skip_cnt_d = skip_cnt_q + SW'(1);
    end else if (href_fall) begin
      if (phase_q || (x_cnt_q != WIDTH_C)) line_err_d = 1'b1;
      x_cnt_d = '0;
      y_cnt_d = (y_cnt_q == CNT_MAX) ? y_cnt_q : y_cnt_q + CW'(1);
      phase_d = 1'b0;
    end else if (href_q) begin
      if (!phase_q) begin
        hi_d    = data_q;
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        if ((x_cnt_q < WIDTH_C) && (y_cnt_q < HEIGHT_C)) begin
          pix_data_d = {hi_q, data_q};
          pix_x_d    = x_cnt_q;
          pix_y_d    = y_cnt_q;
          pix_de_d   = 1'b1;
          x_cnt_d    = x_cnt_q + CW'(1);
        end else begin
          line_err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      skip_cnt_q   <= '0;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      line_err_q   <= 1'b0;
      pix_data_q   <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_de_q     <= 1'b0;
      pix_vs_q     <= 1'b0;
      size_err_q   <= 1'b0;
      capture_on_q <= 1'b0;
    end else begin
      skip_cnt_q   <= skip_cnt_d;
      x_cnt_q      <= x_cnt_d;
      y_cnt_q      <= y_cnt_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      line_err_q   <= line_err_d;
      pix_data_q   <= pix_data_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_de_q     <= pix_de_d;
      pix_vs_q     <= pix_vs_d;
      size_err_q   <= size_err_d;
      capture_on_q <= capture_on_d;
    end
  end

  assign pix_data   = pix_data_q;
  assign pix_de     = pix_de_q;
  assign pix_vs     = pix_vs_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign size_err   = size_err_q;
  assign capture_on = capture_on_q;

endmodule

// File: tb/tb_ov5640_dvp_capture.sv
// Randomized bench for ov5640_dvp_capture: a frame/line level reference model
// schedules expected outputs per cycle and a monitor compares every cycle.
module tb_ov5640_dvp_capture;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int SK = 2;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_done = 1'b0;
  logic        cmos_vsync = 1'b0;
  logic        cmos_href = 1'b0;
  logic [7:0]  cmos_data = 8'h00;
  logic [15:0] pix_data;
  logic        pix_de, pix_vs, size_err, capture_on;
  logic [11:0] pix_x, pix_y;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected outputs keyed by cycle number
  logic [39:0] exp_pix [int];
  bit          exp_vs  [int];
  bit          cap_chg [int];
  bit          cap_exp = 1'b0;

  // Model state: mode 0 = waiting for config, 1 = skipping, 2 = capturing
  int       mode = 0;
  int       skips = 0;
  int       m_x = 0;
  int       m_y = 0;
  bit       m_bad = 1'b0;
  logic [7:0] byte_q [$];

  ov5640_dvp_capture #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .SKIP_FRAMES (SK)
  ) dut (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .cfg_done  (cfg_done),
    .cmos_vsync(cmos_vsync),
    .cmos_href (cmos_href),
    .cmos_data (cmos_data),
    .pix_data  (pix_data),
    .pix_de    (pix_de),
    .pix_vs    (pix_vs),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .size_err  (size_err),
    .capture_on(capture_on)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (cap_chg.exists(cyc)) cap_exp = cap_chg[cyc];
    check("pix_de", 40'(pix_de), 40'(exp_pix.exists(cyc)));
    if (exp_pix.exists(cyc)) check("pix_data_xy", {pix_data, pix_x, pix_y}, exp_pix[cyc]);
    check("pix_vs", 40'(pix_vs), 40'(exp_vs.exists(cyc)));
    check("size_err", 40'(size_err), exp_vs.exists(cyc) ? 40'(exp_vs[cyc]) : 40'(0));
    check("capture_on", 40'(capture_on), 40'(cap_exp));
  end

  task automatic check_zero(input string tag);
    check({tag, "_pix"}, {pix_data, pix_x, pix_y}, 40'(0));
    check({tag, "_ctl"}, 40'({pix_de, pix_vs, size_err, capture_on}), 40'(0));
  endtask

  task automatic new_frame();
    m_x = 0;
    m_y = 0;
    m_bad = 1'b0;
  endtask

  task automatic clear_future(input int c);
    int ks[$];
    foreach (exp_pix[k]) if (k > c) ks.push_back(k);
    foreach (exp_vs[k])  if (k > c) ks.push_back(k);
    foreach (cap_chg[k]) if (k > c) ks.push_back(k);
    foreach (ks[j]) begin
      if (exp_pix.exists(ks[j])) exp_pix.delete(ks[j]);
      if (exp_vs.exists(ks[j]))  exp_vs.delete(ks[j]);
      if (cap_chg.exists(ks[j])) cap_chg.delete(ks[j]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      cmos_href  = 1'b0;
      cmos_vsync = 1'b0;
    end
  endtask

  task automatic fill_rand(input int n);
    byte_q.delete();
    repeat (n) byte_q.push_back(8'($urandom));
  endtask

  task automatic fill_seq(input int n);
    logic [7:0] b;
    b = 8'h12;
    byte_q.delete();
    repeat (n) begin
      byte_q.push_back(b);
      b = b + 8'h22;
    end
  endtask

  task automatic set_cfg(input bit v);
    int c;
    @(negedge clk_i);
    c = cyc;
    cfg_done = v;
    if (!v) begin
      if (mode == 2) cap_chg[c + 1] = 1'b0;
      mode  = 0;
      skips = 0;
    end else if (mode == 0) begin
      mode = 1;
    end
    idle(2);
  endtask

  // One vsync pulse; frame start is seen two cycles after vsync is driven
  task automatic vsync_pulse();
    int c;
    @(negedge clk_i);
    c = cyc;
    cmos_vsync = 1'b1;
    cmos_href  = 1'b0;
    if (mode == 1) begin
      skips++;
      if (skips >= SK) begin
        mode = 2;
        exp_vs[c + 2]  = 1'b0;
        cap_chg[c + 2] = 1'b1;
        new_frame();
      end
    end else if (mode == 2) begin
      exp_vs[c + 2] = (m_y != H) || m_bad;
      new_frame();
    end
    repeat (2) @(negedge clk_i);
    idle(4);
  endtask

  // Sends byte_q as one line; optionally drops cfg_done or asserts reset at a byte index
  task automatic send_line(input int drop_at = -1, input int rst_at = -1);
    int n, c, cut;
    bit live;
    n    = byte_q.size();
    live = (mode == 2);
    cut  = (drop_at >= 0) ? drop_at : rst_at;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      c = cyc;
      cmos_href = 1'b1;
      cmos_data = byte_q[i];
      if (i == drop_at) begin
        cfg_done = 1'b0;
        if (mode == 2) cap_chg[c + 1] = 1'b0;
        mode  = 0;
        skips = 0;
        live  = 1'b0;
      end
      if (i == rst_at) begin
        #2;
        rst_n    = 1'b0;
        cfg_done = 1'b0;
        clear_future(c);
        cap_chg[c + 1] = 1'b0;
        mode  = 0;
        skips = 0;
        live  = 1'b0;
        #1;
        check_zero("rst_async");
      end
      if (live && (i % 2 == 1) && (cut < 0 || i <= cut - 2)) begin
        if (m_x < W && m_y < H) begin
          exp_pix[c + 2] = {byte_q[i-1], byte_q[i], 12'(m_x), 12'(m_y)};
          m_x++;
        end else begin
          m_bad = 1'b1;
        end
      end
    end
    @(negedge clk_i);
    cmos_href = 1'b0;
    if (live) begin
      if ((n % 2 == 1) || (m_x != W)) m_bad = 1'b1;
      m_x = 0;
      if (m_y < 4095) m_y++;
    end
    idle(2);
    if (rst_at >= 0) begin
      @(negedge clk_i);
      rst_n = 1'b1;
    end
  endtask

  task automatic rand_frame();
    int lens[7];
    int nl;
    lens = '{8, 8, 8, 7, 9, 12, 6};
    nl = int'($urandom_range(1, 3));
    repeat (nl) begin
      fill_rand(lens[$urandom_range(0, 6)]);
      send_line();
      idle(int'($urandom_range(0, 2)));
    end
    vsync_pulse();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk_i);
    check_zero("por");
    rst_n = 1'b1;

    // Config not done: vsync and lines are ignored
    repeat (5) begin
      fill_rand(8); send_line();
      vsync_pulse();
    end

    // Two settling frames, capture starts on the second vsync
    set_cfg(1'b1);
    vsync_pulse();
    fill_rand(8); send_line();
    fill_rand(8); send_line();
    vsync_pulse();

    // Clean frame with known first pixel 0x1234
    fill_seq(8);  send_line();
    fill_rand(8); send_line();
    vsync_pulse();

    // Odd byte count, then a clean frame
    fill_rand(9); send_line();
    fill_rand(8); send_line();
    vsync_pulse();
    fill_rand(8); send_line();
    fill_rand(8); send_line();
    vsync_pulse();

    // Oversize line, then too many lines, then clean
    fill_rand(12); send_line();
    fill_rand(8);  send_line();
    vsync_pulse();
    repeat (3) begin fill_rand(8); send_line(); end
    vsync_pulse();
    repeat (2) begin fill_rand(8); send_line(); end
    vsync_pulse();

    repeat (10) rand_frame();

    // Config lost mid-line, then re-acquired with two skipped frames
    fill_rand(8); send_line(5, -1);
    idle(3);
    set_cfg(1'b1);
    vsync_pulse();
    fill_rand(8); send_line();
    vsync_pulse();
    repeat (2) begin fill_rand(8); send_line(); end
    vsync_pulse();
    repeat (3) rand_frame();

    // Asynchronous reset mid-line, then vsyncs with config low
    fill_rand(8); send_line(-1, 5);
    repeat (5) begin
      fill_rand(8); send_line();
      vsync_pulse();
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ov5640_dvp_capture.md
Name: ov5640_dvp_capture

Overview:
- Capture stage directly downstream of the OV5640 I2C configuration block.
- Holds off until `cfg_done` is high, discards the first `SKIP_FRAMES` frames while sensor exposure settles, then converts the 8-bit DVP byte stream into 16-bit RGB565 pixels.
- Emits pixels with frame-start pulse and x/y coordinates to the frame-difference tracker, and flags geometry errors.

Parameters:
- `IMAGE_WIDTH`, 1280, expected pixels per line; legal range 1..4095.
- `IMAGE_HEIGHT`, 720, expected lines per frame; legal range 1..4095.
- `SKIP_FRAMES`, 10, frames discarded after `cfg_done`; legal range 0..255.

Ports:
- `clk_i`  in  1  pixel clock, driven by the sensor PCLK.
- `rst_n`  in  1  asynchronous active-low reset.
- `cfg_done`  in  1  sensor configuration complete; level signal from the config block.
- `cmos_vsync`  in  1  DVP VSYNC, active high during vertical blanking.
- `cmos_href`  in  1  DVP HREF, high while line bytes are valid.
- `cmos_data`  in  8  DVP data byte.
- `pix_data`  out  16  RGB565 pixel, first byte in [15:8].
- `pix_de`  out  1  pixel valid strobe.
- `pix_vs`  out  1  one-cycle frame-start pulse.
- `pix_x`  out  12  column of the current pixel.
- `pix_y`  out  12  line of the current pixel.
- `size_err`  out  1  one-cycle pulse: the previous frame's geometry was wrong.
- `capture_on`  out  1  high while in state ACTIVE.

Behaviour:
- Reset (async assert, sync deassert): all outputs 0, state WAIT_CFG, all counters 0.
- Input stage: `cmos_vsync`, `cmos_href` and `cmos_data` are registered once.
- `vs_rise` = registered vsync is 1 and its previous registered value is 0.
- States:
  - WAIT_CFG: go to SKIP when `cfg_done` is 1.
  - SKIP: increment `skip_cnt` on each `vs_rise`; go to ACTIVE on the `vs_rise` that makes `skip_cnt == SKIP_FRAMES`.
  - With `SKIP_FRAMES = 0`, the first `vs_rise` moves SKIP to ACTIVE.
  - ACTIVE: capture runs; stays in ACTIVE until `cfg_done` falls.
- `cfg_done` low in any state: next cycle is WAIT_CFG, with `pix_de`, `capture_on` and the byte phase cleared and `skip_cnt` reset. A partial pixel is dropped and no `size_err` is raised.
- On each `vs_rise` in ACTIVE, including the entry edge:
  - `pix_vs` = 1 for one cycle.
  - `x_cnt`, `y_cnt` and the byte phase are cleared.
  - `size_err` pulses in the same cycle if a checked frame preceded this edge and either `y_cnt != IMAGE_HEIGHT` or the line-error flag is set. The flag is then cleared.
  - The frame ending at the entry edge is not checked.
- Byte packing (ACTIVE, registered href = 1):
  - Phase 0 latches the byte into the high half.
  - Phase 1 forms the pixel and raises `pix_de`.
  - Latency: the second byte present on `cmos_data` in cycle t gives `pix_de` = 1 in cycle t+2.
  - `pix_de` is never high on two consecutive cycles.
- Coordinates: `pix_x`/`pix_y` are valid with `pix_de`; `x_cnt` increments after each emitted pixel.
- End of line (href falling):
  - Line-error flag is set if the byte phase is 1 (odd byte count; partial byte discarded) or if `x_cnt != IMAGE_WIDTH`.
  - Then `x_cnt` = 0, `y_cnt` += 1 (saturating at 4095), phase = 0.
- Overflow: a pixel with `x_cnt >= IMAGE_WIDTH` or `y_cnt >= IMAGE_HEIGHT` is suppressed (no `pix_de`) and sets the line-error flag.
- `pix_data` holds its last value when `pix_de` = 0.
- Href high while vsync high: bytes are still packed, with no special case.
- Simultaneous `vs_rise` and an href falling edge: the frame clear wins.

Test Plan:
- Reset mid-line, with `IMAGE_WIDTH=4`, `IMAGE_HEIGHT=2`, `SKIP_FRAMES=2`: assert `rst_n` = 0 → all outputs 0 asynchronously. After release with `cfg_done` = 0, five vsync pulses → no `pix_vs`, `capture_on` = 0.
- Skip count: `cfg_done` = 1, then 2 vsync rises → `capture_on` rises on the 2nd. The 1st frame's lines produce no `pix_de`.
- Normal frame: 2 lines of bytes 0x12,0x34,… (8 bytes per line) → 4 `pix_de` per line; first `pix_data` = 0x1234 at `pix_x` = 0, `pix_y` = 0 with 2-cycle latency. Next vsync rise → `pix_vs` = 1, `size_err` = 0.
- Odd bytes: a line of 9 bytes → 4 pixels, 9th byte dropped. Next `vs_rise` → `size_err` = 1. The following clean frame → `size_err` = 0.
- Oversize: a line of 12 bytes → only 4 `pix_de`, then `size_err` at the next `vs_rise`. A frame of 3 lines → the third line is suppressed and `size_err` = 1.
- `cfg_done` drop mid-line → `pix_de` = 0 from the next cycle, `capture_on` = 0. When `cfg_done` returns → 2 more frames are skipped before capture resumes.
